// File: rtl/alu_rs_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_issue_pkg
// Brief    : Shared widths and ctrl bit positions for the reservation stations
// Revision : 1.0 - initial release
// ============================================================================
package alu_rs_issue_pkg;

    localparam int c_tag_w_default = 4;
    localparam int c_data_w        = 32;
    localparam int c_pc_w          = 32;
    localparam int c_instr_w       = 32;

    // dp_ctrl / iss_ctrl packing
    localparam int c_ctrl_w        = 9;
    localparam int c_ctrl_ldic     = 8;
    localparam int c_ctrl_signex   = 7;
    localparam int c_ctrl_immed    = 6;
    localparam int c_ctrl_alu_hi   = 5;
    localparam int c_ctrl_alu_lo   = 2;
    localparam int c_ctrl_jump     = 1;
    localparam int c_ctrl_jr       = 0;

endpackage : alu_rs_issue_pkg
`default_nettype wire

// File: rtl/alu_rs_issue_rs_wakeup_entry.sv
`default_nettype none
// ============================================================================
// Module   : rs_wakeup_entry
// Brief    : Operand-ready/value update of one station slot against the CDB
// Revision : 1.0 - initial release
// ============================================================================
module rs_wakeup_entry
    import alu_rs_issue_pkg::*;
#(
    parameter int TAG_W = c_tag_w_default
) (
    input  logic                i_valid,
    input  logic                i_rs_rdy,
    input  logic [TAG_W-1:0]    i_rs_tag,
    input  logic [c_data_w-1:0] i_rs_val,
    input  logic                i_rt_rdy,
    input  logic [TAG_W-1:0]    i_rt_tag,
    input  logic [c_data_w-1:0] i_rt_val,
    input  logic                i_cdb_valid,
    input  logic [TAG_W-1:0]    i_cdb_tag,
    input  logic [c_data_w-1:0] i_cdb_data,
    output logic                o_rs_rdy,
    output logic [c_data_w-1:0] o_rs_val,
    output logic                o_rt_rdy,
    output logic [c_data_w-1:0] o_rt_val
);

    logic w_rs_hit;
    logic w_rt_hit;

    // Inputs are the slot's post-shift (or freshly dispatched) contents,
    // so a match here covers both normal wakeup and dispatch bypass.
    assign w_rs_hit = i_valid & i_cdb_valid & ~i_rs_rdy & (i_rs_tag == i_cdb_tag);
    assign w_rt_hit = i_valid & i_cdb_valid & ~i_rt_rdy & (i_rt_tag == i_cdb_tag);

    assign o_rs_rdy = i_rs_rdy | w_rs_hit;
    assign o_rs_val = w_rs_hit ? i_cdb_data : i_rs_val;
    assign o_rt_rdy = i_rt_rdy | w_rt_hit;
    assign o_rt_val = w_rt_hit ? i_cdb_data : i_rt_val;

endmodule : rs_wakeup_entry
`default_nettype wire

// File: rtl/alu_rs_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_issue
// Brief    : ALU/branch reservation station, oldest-ready select, issue register
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs_issue
    import alu_rs_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = c_tag_w_default
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 dp_valid,
    output logic                 dp_ready,
    input  logic [TAG_W-1:0]     dp_rob_tag,
    input  logic                 dp_rs_rdy,
    input  logic                 dp_rt_rdy,
    input  logic [TAG_W-1:0]     dp_rs_tag,
    input  logic [TAG_W-1:0]     dp_rt_tag,
    input  logic [c_data_w-1:0]  dp_rs_val,
    input  logic [c_data_w-1:0]  dp_rt_val,
    input  logic [c_pc_w-1:0]    dp_pc_1,
    input  logic [c_instr_w-1:0] dp_instr,
    input  logic [c_ctrl_w-1:0]  dp_ctrl,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [c_data_w-1:0]  cdb_data,
    input  logic                 ex_ready,
    output logic                 iss_valid,
    output logic [TAG_W-1:0]     iss_rob_tag,
    output logic [c_data_w-1:0]  iss_rs_data,
    output logic [c_data_w-1:0]  iss_rt_data,
    output logic [c_pc_w-1:0]    iss_pc_1,
    output logic [c_instr_w-1:0] iss_instr,
    output logic [c_ctrl_w-1:0]  iss_ctrl
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_idx_w = $clog2(DEPTH);

    // ---------------- station storage ----------------
    logic [c_cnt_w-1:0]   r_count;
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_rs_rdy;
    logic [DEPTH-1:0]     r_rt_rdy;
    logic [TAG_W-1:0]     r_rob_tag [DEPTH];
    logic [TAG_W-1:0]     r_rs_tag  [DEPTH];
    logic [TAG_W-1:0]     r_rt_tag  [DEPTH];
    logic [c_data_w-1:0]  r_rs_val  [DEPTH];
    logic [c_data_w-1:0]  r_rt_val  [DEPTH];
    logic [c_pc_w-1:0]    r_pc_1    [DEPTH];
    logic [c_instr_w-1:0] r_instr   [DEPTH];
    logic [c_ctrl_w-1:0]  r_ctrl    [DEPTH];

    // upper neighbour of each slot, used when the queue collapses
    logic [DEPTH-1:0]     w_up_valid;
    logic [DEPTH-1:0]     w_up_rs_rdy;
    logic [DEPTH-1:0]     w_up_rt_rdy;
    logic [TAG_W-1:0]     w_up_rob_tag [DEPTH];
    logic [TAG_W-1:0]     w_up_rs_tag  [DEPTH];
    logic [TAG_W-1:0]     w_up_rt_tag  [DEPTH];
    logic [c_data_w-1:0]  w_up_rs_val  [DEPTH];
    logic [c_data_w-1:0]  w_up_rt_val  [DEPTH];
    logic [c_pc_w-1:0]    w_up_pc_1    [DEPTH];
    logic [c_instr_w-1:0] w_up_instr   [DEPTH];
    logic [c_ctrl_w-1:0]  w_up_ctrl    [DEPTH];

    // candidate next contents before wakeup
    logic [DEPTH-1:0]     w_c_valid;
    logic [DEPTH-1:0]     w_c_rs_rdy;
    logic [DEPTH-1:0]     w_c_rt_rdy;
    logic [TAG_W-1:0]     w_c_rob_tag [DEPTH];
    logic [TAG_W-1:0]     w_c_rs_tag  [DEPTH];
    logic [TAG_W-1:0]     w_c_rt_tag  [DEPTH];
    logic [c_data_w-1:0]  w_c_rs_val  [DEPTH];
    logic [c_data_w-1:0]  w_c_rt_val  [DEPTH];
    logic [c_pc_w-1:0]    w_c_pc_1    [DEPTH];
    logic [c_instr_w-1:0] w_c_instr   [DEPTH];
    logic [c_ctrl_w-1:0]  w_c_ctrl    [DEPTH];

    logic [DEPTH-1:0]     w_wk_rs_rdy;
    logic [DEPTH-1:0]     w_wk_rt_rdy;
    logic [c_data_w-1:0]  w_wk_rs_val [DEPTH];
    logic [c_data_w-1:0]  w_wk_rt_val [DEPTH];

    logic [DEPTH-1:0]     w_rdy;
    logic                 w_found;
    logic [c_idx_w-1:0]   w_sel;
    logic                 w_iss_fire;
    logic                 w_dp_fire;
    logic [c_cnt_w-1:0]   w_wr_idx;

    // ---------------- issue register ----------------
    logic                 r_iss_valid;
    logic [TAG_W-1:0]     r_iss_rob_tag;
    logic [c_data_w-1:0]  r_iss_rs_data;
    logic [c_data_w-1:0]  r_iss_rt_data;
    logic [c_pc_w-1:0]    r_iss_pc_1;
    logic [c_instr_w-1:0] r_iss_instr;
    logic [c_ctrl_w-1:0]  r_iss_ctrl;

    assign dp_ready   = (r_count < c_cnt_w'(DEPTH));
    assign w_dp_fire  = dp_valid & dp_ready;
    assign w_rdy      = r_valid & r_rs_rdy & r_rt_rdy;
    assign w_iss_fire = w_found & (~r_iss_valid | ex_ready);
    assign w_wr_idx   = r_count - {{(c_cnt_w-1){1'b0}}, w_iss_fire};

    // lowest index wins: scan downward so the last hit is the oldest
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_found = 1'b1;
                w_sel   = c_idx_w'(i);
            end
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_up
            if (g < DEPTH - 1) begin : g_up_mid
                assign w_up_valid[g]   = r_valid[g+1];
                assign w_up_rs_rdy[g]  = r_rs_rdy[g+1];
                assign w_up_rt_rdy[g]  = r_rt_rdy[g+1];
                assign w_up_rob_tag[g] = r_rob_tag[g+1];
                assign w_up_rs_tag[g]  = r_rs_tag[g+1];
                assign w_up_rt_tag[g]  = r_rt_tag[g+1];
                assign w_up_rs_val[g]  = r_rs_val[g+1];
                assign w_up_rt_val[g]  = r_rt_val[g+1];
                assign w_up_pc_1[g]    = r_pc_1[g+1];
                assign w_up_instr[g]   = r_instr[g+1];
                assign w_up_ctrl[g]    = r_ctrl[g+1];
            end else begin : g_up_top
                assign w_up_valid[g]   = 1'b0;
                assign w_up_rs_rdy[g]  = 1'b0;
                assign w_up_rt_rdy[g]  = 1'b0;
                assign w_up_rob_tag[g] = '0;
                assign w_up_rs_tag[g]  = '0;
                assign w_up_rt_tag[g]  = '0;
                assign w_up_rs_val[g]  = '0;
                assign w_up_rt_val[g]  = '0;
                assign w_up_pc_1[g]    = '0;
                assign w_up_instr[g]   = '0;
                assign w_up_ctrl[g]    = '0;
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_c_valid[i]   = r_valid[i];
            w_c_rs_rdy[i]  = r_rs_rdy[i];
            w_c_rt_rdy[i]  = r_rt_rdy[i];
            w_c_rob_tag[i] = r_rob_tag[i];
            w_c_rs_tag[i]  = r_rs_tag[i];
            w_c_rt_tag[i]  = r_rt_tag[i];
            w_c_rs_val[i]  = r_rs_val[i];
            w_c_rt_val[i]  = r_rt_val[i];
            w_c_pc_1[i]    = r_pc_1[i];
            w_c_instr[i]   = r_instr[i];
            w_c_ctrl[i]    = r_ctrl[i];
            if (w_iss_fire && (i >= int'(w_sel))) begin
                w_c_valid[i]   = w_up_valid[i];
                w_c_rs_rdy[i]  = w_up_rs_rdy[i];
                w_c_rt_rdy[i]  = w_up_rt_rdy[i];
                w_c_rob_tag[i] = w_up_rob_tag[i];
                w_c_rs_tag[i]  = w_up_rs_tag[i];
                w_c_rt_tag[i]  = w_up_rt_tag[i];
                w_c_rs_val[i]  = w_up_rs_val[i];
                w_c_rt_val[i]  = w_up_rt_val[i];
                w_c_pc_1[i]    = w_up_pc_1[i];
                w_c_instr[i]   = w_up_instr[i];
                w_c_ctrl[i]    = w_up_ctrl[i];
            end
            if (w_dp_fire && (int'(w_wr_idx) == i)) begin
                w_c_valid[i]   = 1'b1;
                w_c_rs_rdy[i]  = dp_rs_rdy;
                w_c_rt_rdy[i]  = dp_rt_rdy;
                w_c_rob_tag[i] = dp_rob_tag;
                w_c_rs_tag[i]  = dp_rs_tag;
                w_c_rt_tag[i]  = dp_rt_tag;
                w_c_rs_val[i]  = dp_rs_val;
                w_c_rt_val[i]  = dp_rt_val;
                w_c_pc_1[i]    = dp_pc_1;
                w_c_instr[i]   = dp_instr;
                w_c_ctrl[i]    = dp_ctrl;
            end
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_wakeup
            rs_wakeup_entry #(
                .TAG_W (TAG_W)
            ) u_wakeup (
                .i_valid     (w_c_valid[g]),
                .i_rs_rdy    (w_c_rs_rdy[g]),
                .i_rs_tag    (w_c_rs_tag[g]),
                .i_rs_val    (w_c_rs_val[g]),
                .i_rt_rdy    (w_c_rt_rdy[g]),
                .i_rt_tag    (w_c_rt_tag[g]),
                .i_rt_val    (w_c_rt_val[g]),
                .i_cdb_valid (cdb_valid),
                .i_cdb_tag   (cdb_tag),
                .i_cdb_data  (cdb_data),
                .o_rs_rdy    (w_wk_rs_rdy[g]),
                .o_rs_val    (w_wk_rs_val[g]),
                .o_rt_rdy    (w_wk_rt_rdy[g]),
                .o_rt_val    (w_wk_rt_val[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid  <= w_c_valid;
            r_rs_rdy <= w_wk_rs_rdy;
            r_rt_rdy <= w_wk_rt_rdy;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob_tag[i] <= w_c_rob_tag[i];
                r_rs_tag[i]  <= w_c_rs_tag[i];
                r_rt_tag[i]  <= w_c_rt_tag[i];
                r_rs_val[i]  <= w_wk_rs_val[i];
                r_rt_val[i]  <= w_wk_rt_val[i];
                r_pc_1[i]    <= w_c_pc_1[i];
                r_instr[i]   <= w_c_instr[i];
                r_ctrl[i]    <= w_c_ctrl[i];
            end
            case ({w_dp_fire, w_iss_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue register loads from registered state, so a same-edge wakeup
    // can never reach it; outputs freeze while ex_ready is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iss_valid   <= 1'b0;
            r_iss_rob_tag <= '0;
            r_iss_rs_data <= '0;
            r_iss_rt_data <= '0;
            r_iss_pc_1    <= '0;
            r_iss_instr   <= '0;
            r_iss_ctrl    <= '0;
        end else if (flush) begin
            r_iss_valid <= 1'b0;
        end else if (w_iss_fire) begin
            r_iss_valid   <= 1'b1;
            r_iss_rob_tag <= r_rob_tag[w_sel];
            r_iss_rs_data <= r_rs_val[w_sel];
            r_iss_rt_data <= r_rt_val[w_sel];
            r_iss_pc_1    <= r_pc_1[w_sel];
            r_iss_instr   <= r_instr[w_sel];
            r_iss_ctrl    <= r_ctrl[w_sel];
        end else if (ex_ready) begin
            r_iss_valid <= 1'b0;
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_rob_tag = r_iss_rob_tag;
    assign iss_rs_data = r_iss_rs_data;
    assign iss_rt_data = r_iss_rt_data;
    assign iss_pc_1    = r_iss_pc_1;
    assign iss_instr   = r_iss_instr;
    assign iss_ctrl    = r_iss_ctrl;

endmodule : alu_rs_issue
`default_nettype wire
